uart_ctrl_sequencer: RTL

- Front-end controller that owns the uart_top addr/data configuration bus.
- Accepts line-configuration requests, buffers TX bytes in a FIFO and takes receive requests.
- Drives the register sequence: baud, parity, frame length and stop bit, then transmit or receive.
- Holds each command until the matching done edge; only one operation is in flight at a time.

---
 rtl/uart_ctrl_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uart_ctrl_sequencer
// Function : Drives the uart_top addr/data bus through the line-configuration
//            sequence and one TX byte (from a FIFO) or RX request at a time.
// Revision : 1.0 - initial release
// ============================================================================
module uart_ctrl_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int CFG_HOLD   = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [1:0]                    cfg_baud,
  input  logic [1:0]                    cfg_parity,
  input  logic [3:0]                    cfg_frame_len,
  input  logic                          cfg_stop,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          rx_req,
  output logic [7:0]                    rx_data,
  output logic                          rx_data_valid,
  output logic [2:0]                    uart_addr,
  output logic [7:0]                    uart_data,
  input  logic                          uart_tx_done,
  input  logic                          uart_rx_done,
  input  logic [7:0]                    uart_rx_data,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_HOLD_W = (CFG_HOLD > 1) ? $clog2(CFG_HOLD) : 1;
  localparam int c_TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(CFG_HOLD - 1);
  localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0]  c_DEPTH     = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CFG_BAUD = 3'd1,
    S_CFG_PAR  = 3'd2,
    S_CFG_LEN  = 3'd3,
    S_CFG_STOP = 3'd4,
    S_TX_RUN   = 3'd5,
    S_RX_RUN   = 3'd6
  } state_t;

  state_t                r_state, w_state_next;
  logic [c_HOLD_W-1:0]   r_hold;
  logic [c_TMO_W-1:0]    r_tmo;
  logic [1:0]            r_baud, r_parity, w_baud_n, w_parity_n;
  logic [3:0]            r_frame_len, w_frame_len_n;
  logic                  r_stop, w_stop_n;
  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count, w_count_n;
  logic                  r_tx_done_q, r_rx_done_q;
  logic                  r_cfg_ready, r_wr_ready, r_busy, r_rx_valid, r_tmo_err;
  logic [7:0]            r_rx_data, r_uart_data, w_data_n;
  logic [2:0]            r_uart_addr, w_addr_n;
  logic                  w_cfg_take, w_pop, w_push, w_rx_take, w_tmo_fire;
  logic                  w_tx_rise, w_rx_rise, w_hold_end, w_tmo_hit;

  assign w_tx_rise  = uart_tx_done & ~r_tx_done_q;
  assign w_rx_rise  = uart_rx_done & ~r_rx_done_q;
  assign w_hold_end = (r_hold == c_HOLD_LAST);
  assign w_tmo_hit  = (TIMEOUT != 0) && (r_tmo == c_TMO_LAST);
  assign w_push     = wr_valid & r_wr_ready;

  always_comb begin
    w_state_next = r_state;
    w_cfg_take   = 1'b0;
    w_pop        = 1'b0;
    w_rx_take    = 1'b0;
    w_tmo_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_valid && r_cfg_ready) begin
          w_cfg_take   = 1'b1;
          w_state_next = S_CFG_BAUD;
        end else if (r_count != '0) begin
          w_state_next = S_TX_RUN;
        end else if (rx_req) begin
          w_state_next = S_RX_RUN;
        end
      end
      S_CFG_BAUD: if (w_hold_end) w_state_next = S_CFG_PAR;
      S_CFG_PAR:  if (w_hold_end) w_state_next = S_CFG_LEN;
      S_CFG_LEN:  if (w_hold_end) w_state_next = S_CFG_STOP;
      S_CFG_STOP: if (w_hold_end) w_state_next = S_IDLE;
      S_TX_RUN: begin
        if (w_tx_rise) begin
          w_pop        = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_tmo_hit) begin
          // a timed-out byte is dropped so the queue cannot wedge
          w_pop        = 1'b1;
          w_tmo_fire   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_RX_RUN: begin
        if (w_rx_rise) begin
          w_rx_take    = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_tmo_hit) begin
          w_tmo_fire   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    w_baud_n      = w_cfg_take ? cfg_baud      : r_baud;
    w_parity_n    = w_cfg_take ? cfg_parity    : r_parity;
    w_frame_len_n = w_cfg_take ? cfg_frame_len : r_frame_len;
    w_stop_n      = w_cfg_take ? cfg_stop      : r_stop;

    // bus outputs are registered, so they are decoded from the next state
    w_addr_n = 3'b111;
    w_data_n = 8'h00;
    case (w_state_next)
      S_CFG_BAUD: begin w_addr_n = 3'b000; w_data_n = {6'b0, w_baud_n};      end
      S_CFG_PAR:  begin w_addr_n = 3'b001; w_data_n = {6'b0, w_parity_n};    end
      S_CFG_LEN:  begin w_addr_n = 3'b010; w_data_n = {4'b0, w_frame_len_n}; end
      S_CFG_STOP: begin w_addr_n = 3'b011; w_data_n = {7'b0, w_stop_n};      end
      S_TX_RUN:   begin w_addr_n = 3'b100; w_data_n = r_mem[r_rd_ptr];      end
      S_RX_RUN:   begin w_addr_n = 3'b101; w_data_n = 8'h00;                 end
      default:    begin w_addr_n = 3'b111; w_data_n = 8'h00;                 end
    endcase

    w_count_n = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_n = r_count + 1'b1;
      2'b01:   w_count_n = r_count - 1'b1;
      default: w_count_n = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_tmo       <= '0;
      r_baud      <= 2'b11;
      r_parity    <= 2'b01;
      r_frame_len <= 4'd5;
      r_stop      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_tx_done_q <= 1'b0;
      r_rx_done_q <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_wr_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_tmo_err   <= 1'b0;
      r_rx_data   <= 8'h00;
      r_uart_addr <= 3'b111;
      r_uart_data <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_hold      <= (w_state_next != r_state) ? '0 : r_hold + 1'b1;
      r_tmo       <= (w_state_next != r_state) ? '0 : r_tmo + 1'b1;
      r_baud      <= w_baud_n;
      r_parity    <= w_parity_n;
      r_frame_len <= w_frame_len_n;
      r_stop      <= w_stop_n;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_n;
      r_tx_done_q <= uart_tx_done;
      r_rx_done_q <= uart_rx_done;
      r_cfg_ready <= (w_state_next == S_IDLE);
      r_wr_ready  <= (w_count_n < c_DEPTH);
      r_busy      <= (w_state_next != S_IDLE);
      r_rx_valid  <= w_rx_take;
      r_tmo_err   <= w_tmo_fire;
      if (w_rx_take) r_rx_data <= uart_rx_data;
      r_uart_addr <= w_addr_n;
      r_uart_data <= w_data_n;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign cfg_ready     = r_cfg_ready;
  assign wr_ready      = r_wr_ready;
  assign fifo_count    = r_count;
  assign rx_data       = r_rx_data;
  assign rx_data_valid = r_rx_valid;
  assign uart_addr     = r_uart_addr;
  assign uart_data     = r_uart_data;
  assign busy          = r_busy;
  assign timeout_err   = r_tmo_err;

endmodule
`default_nettype wire
